// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: opcodes, func codes, ALU/forward select constants and control bundle for pipe_controller
package pipe_ctrl_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_SLT  = 3'd4;
    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_MEM  = 2'b10;
    localparam logic [1:0] FWD_WB   = 2'b01;
    typedef struct packed {
        logic alu_src_imm;
        logic wmem;
        logic load;
        logic wb;
    } ctrl_t;
endpackage

// File: rtl/pipe_controller_hazard_unit.sv
// hazard_unit: combinational load-use/branch stall detection plus EX and ID forwarding selects
module hazard_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter bit BRANCH_FWD = 1'b1
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rt,
    input  logic                  use_rs,
    input  logic                  use_rt,
    input  logic                  is_branch,
    input  logic                  ex_load,
    input  logic                  ex_wb,
    input  logic [REG_ADDR_W-1:0] ex_dst,
    input  logic [REG_ADDR_W-1:0] ex_rs,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  mem_load,
    input  logic                  mem_wb,
    input  logic [REG_ADDR_W-1:0] mem_dst,
    input  logic                  wb_wb,
    input  logic [REG_ADDR_W-1:0] wb_dst,
    output logic                  haz_stall,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  fwd_id_a,
    output logic                  fwd_id_b
);
    function automatic logic hit(input logic [REG_ADDR_W-1:0] d, input logic [REG_ADDR_W-1:0] s);
        return d != '0 && d == s;
    endfunction
    logic load_use, br_haz;
    always_comb begin
        load_use = ex_load && ((use_rs && hit(ex_dst, rs)) || (use_rt && hit(ex_dst, rt)));
        br_haz = is_branch && ((ex_wb && (hit(ex_dst, rs) || hit(ex_dst, rt)))
            || ((mem_load || (!BRANCH_FWD && mem_wb)) && (hit(mem_dst, rs) || hit(mem_dst, rt))));
        haz_stall = load_use || br_haz;
        fwd_a = mem_wb && hit(mem_dst, ex_rs) ? FWD_MEM : wb_wb && hit(wb_dst, ex_rs) ? FWD_WB : FWD_RF;
        fwd_b = mem_wb && hit(mem_dst, ex_rt) ? FWD_MEM : wb_wb && hit(wb_dst, ex_rt) ? FWD_WB : FWD_RF;
        fwd_id_a = BRANCH_FWD && mem_wb && !mem_load && hit(mem_dst, rs);
        fwd_id_b = BRANCH_FWD && mem_wb && !mem_load && hit(mem_dst, rt);
    end
endmodule

// File: rtl/pipe_controller.sv
// pipe_controller: 5-stage MIPS ID decode, control pipeline ID/EX..MEM/WB, stall/flush/forward and cache freeze
module pipe_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int ALU_SIG_W  = 3,
    parameter bit ENABLE_IMM = 1'b1,
    parameter bit BRANCH_FWD = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            opcode,
    input  logic [5:0]            func,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rt,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  equal,
    input  logic                  cacheStall,
    output logic                  pcWrite,
    output logic                  ifidWrite,
    output logic                  ifidFlush,
    output logic                  jumpSel,
    output logic                  jumpCondSel,
    output logic [ALU_SIG_W-1:0]  exAluSig,
    output logic                  exAluSrcImm,
    output logic [1:0]            fwdA,
    output logic [1:0]            fwdB,
    output logic                  fwdIdA,
    output logic                  fwdIdB,
    output logic                  memWMEM,
    output logic                  memLoad,
    output logic                  wbWB,
    output logic [REG_ADDR_W-1:0] wbDst
);
    ctrl_t id_c, ex_c;
    logic [2:0] id_alu;
    logic [REG_ADDR_W-1:0] id_dst, ex_dst, ex_rs, ex_rt, mem_dst;
    logic use_rs, use_rt, is_branch, is_jump, taken, haz_stall, mem_wb;
    always_comb begin
        id_c = '0;
        id_alu = ALU_ADD;
        id_dst = '0;
        use_rs = 1'b0;
        use_rt = 1'b0;
        is_branch = 1'b0;
        is_jump = 1'b0;
        taken = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                id_c.wb = func inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
                id_alu = func == FN_SUB ? ALU_SUB : func == FN_AND ? ALU_AND :
                         func == FN_OR ? ALU_OR : func == FN_SLT ? ALU_SLT : ALU_ADD;
                id_dst = id_c.wb ? rd : '0;
                use_rs = id_c.wb;
                use_rt = id_c.wb;
            end
            OP_J: is_jump = 1'b1;
            OP_BEQ, OP_BNE: begin
                is_branch = 1'b1;
                use_rs = 1'b1;
                use_rt = 1'b1;
                taken = (opcode == OP_BEQ) == equal;
            end
            OP_LW: begin
                id_c.alu_src_imm = 1'b1;
                id_c.load = 1'b1;
                id_c.wb = 1'b1;
                id_dst = rt;
                use_rs = 1'b1;
            end
            OP_SW: begin
                id_c.alu_src_imm = 1'b1;
                id_c.wmem = 1'b1;
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: if (ENABLE_IMM) begin
                id_c.alu_src_imm = 1'b1;
                id_c.wb = 1'b1;
                id_dst = rt;
                use_rs = 1'b1;
                id_alu = opcode == OP_ANDI ? ALU_AND : opcode == OP_ORI ? ALU_OR :
                         opcode == OP_SLTI ? ALU_SLT : ALU_ADD;
            end
            default: ;
        endcase
    end
    hazard_unit #(.REG_ADDR_W(REG_ADDR_W), .BRANCH_FWD(BRANCH_FWD)) u_haz (
        .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt), .is_branch(is_branch),
        .ex_load(ex_c.load), .ex_wb(ex_c.wb), .ex_dst(ex_dst), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .mem_load(memLoad), .mem_wb(mem_wb), .mem_dst(mem_dst), .wb_wb(wbWB), .wb_dst(wbDst),
        .haz_stall(haz_stall), .fwd_a(fwdA), .fwd_b(fwdB), .fwd_id_a(fwdIdA), .fwd_id_b(fwdIdB)
    );
    assign pcWrite = !rst && !cacheStall && !haz_stall;
    assign ifidWrite = pcWrite;
    assign jumpSel = pcWrite && is_jump;
    assign jumpCondSel = pcWrite && taken;
    assign ifidFlush = jumpSel || jumpCondSel;
    assign exAluSrcImm = ex_c.alu_src_imm;
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_c <= '0;
            exAluSig <= '0;
            ex_dst <= '0;
            ex_rs <= '0;
            ex_rt <= '0;
            memWMEM <= 1'b0;
            memLoad <= 1'b0;
            mem_wb <= 1'b0;
            mem_dst <= '0;
            wbWB <= 1'b0;
            wbDst <= '0;
        end else if (!cacheStall) begin
            ex_c <= haz_stall ? '0 : id_c;
            exAluSig <= haz_stall ? '0 : ALU_SIG_W'(id_alu);
            ex_dst <= haz_stall ? '0 : id_dst;
            ex_rs <= haz_stall ? '0 : rs;
            ex_rt <= haz_stall ? '0 : rt;
            memWMEM <= ex_c.wmem;
            memLoad <= ex_c.load;
            mem_wb <= ex_c.wb;
            mem_dst <= ex_dst;
            wbWB <= mem_wb;
            wbDst <= mem_dst;
        end
    end
endmodule

// File: tb/tb_pipe_controller.sv
// tb_pipe_controller: directed plus random stimulus against an instruction-level pipeline model
module tb_pipe_controller;
    localparam int RW = 5;
    localparam int AW = 3;
    localparam bit BF = 1'b1;
    localparam logic [5:0] RFN [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    localparam logic [5:0] IOP [4] = '{6'h08, 6'h0c, 6'h0d, 6'h0a};
    localparam int ICODE [4] = '{0, 2, 3, 4};
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [5:0] opcode = '0, func = '0;
    logic [RW-1:0] rs = '0, rt = '0, rd = '0;
    logic equal = 1'b0, cacheStall = 1'b0;
    logic pcWrite, ifidWrite, ifidFlush, jumpSel, jumpCondSel, exAluSrcImm, fwdIdA, fwdIdB;
    logic memWMEM, memLoad, wbWB;
    logic [AW-1:0] exAluSig;
    logic [1:0] fwdA, fwdB;
    logic [RW-1:0] wbDst;
    pipe_controller #(.REG_ADDR_W(RW), .ALU_SIG_W(AW), .ENABLE_IMM(1'b1), .BRANCH_FWD(BF)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func(func), .rs(rs), .rt(rt), .rd(rd),
        .equal(equal), .cacheStall(cacheStall), .pcWrite(pcWrite), .ifidWrite(ifidWrite),
        .ifidFlush(ifidFlush), .jumpSel(jumpSel), .jumpCondSel(jumpCondSel), .exAluSig(exAluSig),
        .exAluSrcImm(exAluSrcImm), .fwdA(fwdA), .fwdB(fwdB), .fwdIdA(fwdIdA), .fwdIdB(fwdIdB),
        .memWMEM(memWMEM), .memLoad(memLoad), .wbWB(wbWB), .wbDst(wbDst)
    );
    always #5 clk = ~clk;
    typedef struct packed {
        logic [2:0] alu;
        logic imm, wmem, load, wb;
        logic [RW-1:0] dst, rs, rt;
    } rec_t;
    typedef struct packed {
        rec_t r;
        logic ur, ut, br, jmp, tk;
    } dec_t;
    rec_t ex_s, mem_s, wb_s;
    int n_vec = 0, n_err = 0;
    logic last_pcw = 1'b1;
    logic [7:0] s_pc, s_if, s_fl, s_jc, s_alu, s_imm, s_fa, s_fia, s_ml, s_wb;
    function automatic dec_t decode(input logic [5:0] op, input logic [5:0] fn, input logic [RW-1:0] s,
                                    input logic [RW-1:0] t, input logic [RW-1:0] d, input logic eq);
        dec_t x;
        x = '0;
        x.r.rs = s;
        x.r.rt = t;
        if (op == 6'h00)
            for (int i = 0; i < 5; i++)
                if (fn == RFN[i]) begin
                    x.r.alu = 3'(i);
                    x.r.wb = 1'b1;
                    x.r.dst = d;
                    x.ur = 1'b1;
                    x.ut = 1'b1;
                end
        for (int i = 0; i < 4; i++)
            if (op == IOP[i]) begin
                x.r.alu = 3'(ICODE[i]);
                x.r.imm = 1'b1;
                x.r.wb = 1'b1;
                x.r.dst = t;
                x.ur = 1'b1;
            end
        if (op == 6'h23) begin
            x.r.imm = 1'b1;
            x.r.load = 1'b1;
            x.r.wb = 1'b1;
            x.r.dst = t;
            x.ur = 1'b1;
        end
        if (op == 6'h2b) begin
            x.r.imm = 1'b1;
            x.r.wmem = 1'b1;
            x.ur = 1'b1;
            x.ut = 1'b1;
        end
        if (op == 6'h02) x.jmp = 1'b1;
        if (op == 6'h04 || op == 6'h05) begin
            x.br = 1'b1;
            x.ur = 1'b1;
            x.ut = 1'b1;
            x.tk = (op == 6'h04) ? eq : !eq;
        end
        return x;
    endfunction
    // nearest older writer of r wins: the instruction in MEM, then the one in WB
    function automatic logic [1:0] fwd_for(input logic [RW-1:0] r);
        if (r != 0 && mem_s.wb && mem_s.dst == r) return 2'b10;
        if (r != 0 && wb_s.wb && wb_s.dst == r) return 2'b01;
        return 2'b00;
    endfunction
    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask
    task automatic cyc(input logic [5:0] op, input logic [5:0] fn, input int s, input int t, input int d,
                       input logic eq, input logic cs, input logic r);
        dec_t x;
        rec_t ahead [2];
        logic [RW-1:0] need [2];
        logic stall, pcw, js, jc;
        opcode = op;
        func = fn;
        rs = RW'(s);
        rt = RW'(t);
        rd = RW'(d);
        equal = eq;
        cacheStall = cs;
        rst = r;
        @(negedge clk);
        x = decode(op, fn, rs, rt, rd, eq);
        ahead[0] = ex_s;
        ahead[1] = mem_s;
        need[0] = x.ur ? rs : '0;
        need[1] = x.ut ? rt : '0;
        stall = 1'b0;
        // a source is blocked when its producer cannot deliver in time for the stage that needs it:
        // branches compare in ID, everything else consumes in EX
        for (int k = 0; k < 2; k++)
            for (int j = 0; j < 2; j++)
                if (need[j] != 0 && ahead[k].wb && ahead[k].dst == need[j])
                    if (x.br ? (k == 0 || ahead[k].load || !BF) : (k == 0 && ahead[k].load)) stall = 1'b1;
        pcw = !r && !cs && !stall;
        js = pcw && x.jmp;
        jc = pcw && x.tk;
        chk("pcWrite", 8'(pcWrite), 8'(pcw));
        chk("ifidWrite", 8'(ifidWrite), 8'(pcw));
        chk("jumpSel", 8'(jumpSel), 8'(js));
        chk("jumpCondSel", 8'(jumpCondSel), 8'(jc));
        chk("ifidFlush", 8'(ifidFlush), 8'(js || jc));
        chk("exAluSig", 8'(exAluSig), 8'(ex_s.alu));
        chk("exAluSrcImm", 8'(exAluSrcImm), 8'(ex_s.imm));
        chk("fwdA", 8'(fwdA), 8'(fwd_for(ex_s.rs)));
        chk("fwdB", 8'(fwdB), 8'(fwd_for(ex_s.rt)));
        chk("fwdIdA", 8'(fwdIdA), 8'(BF && rs != 0 && mem_s.wb && !mem_s.load && mem_s.dst == rs));
        chk("fwdIdB", 8'(fwdIdB), 8'(BF && rt != 0 && mem_s.wb && !mem_s.load && mem_s.dst == rt));
        chk("memWMEM", 8'(memWMEM), 8'(mem_s.wmem));
        chk("memLoad", 8'(memLoad), 8'(mem_s.load));
        chk("wbWB", 8'(wbWB), 8'(wb_s.wb));
        chk("wbDst", 8'(wbDst), 8'(wb_s.dst));
        s_pc = 8'(pcWrite);
        s_if = 8'(ifidWrite);
        s_fl = 8'(ifidFlush);
        s_jc = 8'(jumpCondSel);
        s_alu = 8'(exAluSig);
        s_imm = 8'(exAluSrcImm);
        s_fa = 8'(fwdA);
        s_fia = 8'(fwdIdA);
        s_ml = 8'(memLoad);
        s_wb = 8'(wbWB);
        last_pcw = pcw;
        if (r) begin
            ex_s = '0;
            mem_s = '0;
            wb_s = '0;
        end else if (!cs) begin
            wb_s = mem_s;
            mem_s = ex_s;
            ex_s = stall ? '0 : x.r;
        end
        @(posedge clk);
        #1;
    endtask
    task automatic nops(input int n);
        for (int i = 0; i < n; i++) cyc(6'h00, 6'h00, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask
    logic [5:0] c_op, c_fn;
    int c_s, c_t, c_d;
    initial begin
        ex_s = '0;
        mem_s = '0;
        wb_s = '0;
        @(posedge clk);
        #1;
        cyc(6'h00, 6'h20, 1, 2, 3, 1'b0, 1'b0, 1'b1);
        cyc(6'h00, 6'h20, 1, 2, 3, 1'b0, 1'b0, 1'b1);
        chk("rst_pcWrite", s_pc, 8'd0);
        chk("rst_exAluSig", s_alu, 8'd0);
        chk("rst_wbWB", s_wb, 8'd0);
        chk("rst_fwdA", s_fa, 8'd0);
        cyc(6'h00, 6'h20, 1, 2, 3, 1'b0, 1'b0, 1'b0);
        cyc(6'h00, 6'h22, 3, 5, 4, 1'b0, 1'b0, 1'b0);
        chk("post_rst_exAluSig", s_alu, 8'd0);
        chk("post_rst_wbWB", s_wb, 8'd0);
        cyc(6'h00, 6'h24, 3, 7, 6, 1'b0, 1'b0, 1'b0);
        chk("sub_fwdA_mem", s_fa, 8'd2);
        chk("sub_exAluSig", s_alu, 8'd1);
        nops(1);
        chk("and_fwdA_wb", s_fa, 8'd1);
        chk("and_exAluSig", s_alu, 8'd2);
        nops(3);
        cyc(6'h23, 6'h00, 1, 2, 0, 1'b0, 1'b0, 1'b0);
        cyc(6'h00, 6'h20, 2, 3, 4, 1'b0, 1'b0, 1'b0);
        chk("lu_pcWrite", s_pc, 8'd0);
        chk("lu_ifidWrite", s_if, 8'd0);
        cyc(6'h00, 6'h20, 2, 3, 4, 1'b0, 1'b0, 1'b0);
        chk("lu_bubble_alu", s_alu, 8'd0);
        chk("lu_bubble_imm", s_imm, 8'd0);
        chk("lu_memLoad", s_ml, 8'd1);
        chk("lu_resume_pc", s_pc, 8'd1);
        nops(1);
        chk("lu_fwdA_wb", s_fa, 8'd1);
        nops(3);
        cyc(6'h04, 6'h00, 1, 1, 0, 1'b1, 1'b0, 1'b0);
        chk("beq_taken", s_jc, 8'd1);
        chk("beq_flush", s_fl, 8'd1);
        cyc(6'h05, 6'h00, 1, 1, 0, 1'b1, 1'b0, 1'b0);
        chk("bne_not_taken", s_jc, 8'd0);
        chk("bne_no_flush", s_fl, 8'd0);
        cyc(6'h23, 6'h00, 1, 5, 0, 1'b0, 1'b0, 1'b0);
        cyc(6'h04, 6'h00, 5, 0, 0, 1'b1, 1'b0, 1'b0);
        chk("lwbr_stall1", s_pc, 8'd0);
        chk("lwbr_nojump1", s_jc, 8'd0);
        cyc(6'h04, 6'h00, 5, 0, 0, 1'b1, 1'b0, 1'b0);
        chk("lwbr_stall2", s_pc, 8'd0);
        cyc(6'h04, 6'h00, 5, 0, 0, 1'b1, 1'b0, 1'b0);
        chk("lwbr_go", s_pc, 8'd1);
        chk("lwbr_taken", s_jc, 8'd1);
        nops(3);
        cyc(6'h08, 6'h00, 1, 5, 0, 1'b0, 1'b0, 1'b0);
        cyc(6'h04, 6'h00, 5, 0, 0, 1'b0, 1'b0, 1'b0);
        chk("addibr_stall", s_pc, 8'd0);
        cyc(6'h04, 6'h00, 5, 0, 0, 1'b0, 1'b0, 1'b0);
        chk("addibr_go", s_pc, 8'd1);
        chk("addibr_fwdIdA", s_fia, 8'd1);
        chk("addibr_nt", s_jc, 8'd0);
        nops(3);
        cyc(6'h23, 6'h00, 1, 2, 0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(6'h00, 6'h20, 2, 3, 4, 1'b0, 1'b1, 1'b0);
            chk("cs_pcWrite", s_pc, 8'd0);
            chk("cs_frozen_imm", s_imm, 8'd1);
        end
        cyc(6'h00, 6'h20, 2, 3, 4, 1'b0, 1'b0, 1'b0);
        chk("cs_then_lu", s_pc, 8'd0);
        cyc(6'h00, 6'h20, 2, 3, 4, 1'b0, 1'b0, 1'b0);
        chk("cs_resume", s_pc, 8'd1);
        chk("cs_bubble_imm", s_imm, 8'd0);
        nops(3);
        c_op = 6'h00;
        c_fn = 6'h00;
        c_s = 0;
        c_t = 0;
        c_d = 0;
        for (int i = 0; i < 3000; i++) begin
            if (last_pcw) begin
                c_s = $urandom_range(0, 3);
                c_t = $urandom_range(0, 3);
                c_d = $urandom_range(0, 3);
                c_fn = 6'h00;
                case ($urandom_range(0, 7))
                    0, 7: begin c_op = 6'h00; c_fn = RFN[$urandom_range(0, 4)]; end
                    1: c_op = 6'h23;
                    2: c_op = 6'h2b;
                    3: c_op = $urandom_range(0, 1) ? 6'h04 : 6'h05;
                    4: c_op = 6'h02;
                    5: c_op = IOP[$urandom_range(0, 3)];
                    default: c_op = 6'h3f;
                endcase
            end
            cyc(c_op, c_fn, c_s, c_t, c_d, 1'($urandom_range(0, 1)),
                $urandom_range(0, 9) == 0, $urandom_range(0, 99) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
